exec_arbiter: RTL and testbench
===============================

EXEC_ARBITER -- requirements
Module: exec_arbiter

Interface
REQ-001 The block SHALL provide `i_clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL provide `i_rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL provide `i_flush`, input, 1 bit: discards the buffered result and blocks grants this cycle.
REQ-004 The block SHALL provide `req0_valid`/`req1_valid`, input, 1 bit each: requester N presents an operation.
REQ-005 The block SHALL provide `req0_ready`/`req1_ready`, output, 1 bit each: requester N is granted this cycle.
REQ-006 The block SHALL provide `reqN_alu_op` (3 bits), `reqN_alu_src` (1 bit), `reqN_rs1`, `reqN_rs2` and `reqN_imm` (32 bits each), all inputs: the operation fields of requester N.
REQ-007 The block SHALL provide `alu_op` (3), `alu_src_op` (1), `rs1_data` (32), `rs2_data` (32) and `immediate` (32), all outputs: drive to the shared execute unit.
REQ-008 The block SHALL provide `alu_result` (32), `o_eq` (1) and `o_slt` (1), all inputs: combinational results from the execute unit.
REQ-009 The block SHALL provide `rsp_valid`, output, 1 bit; `rsp_ready`, input, 1 bit; `rsp_id`, output, 1 bit (granted port); `rsp_result`, output, 32 bits; `rsp_eq` and `rsp_slt`, outputs, 1 bit each.

Function
REQ-010 Handshake: a request transfers in a cycle where `reqN_valid` and `reqN_ready` are both 1; `reqN_ready` SHALL be 1 for at most one N per cycle.
REQ-011 A grant SHALL be issued only when `i_flush`=0 and the response buffer is empty, or the buffer is draining this cycle (`rsp_valid` & `rsp_ready`).
REQ-012 Grant SHALL NOT depend combinationally on `reqN_ready`; `reqN_valid` SHALL NOT be required to stay asserted without a grant.
REQ-013 Execute-unit outputs SHALL carry the granted port's fields in the grant cycle, and all zeros when there is no grant.
REQ-014 In the grant cycle `alu_result`, `o_eq`, `o_slt` and the port number SHALL be captured; `rsp_valid`=1 from the next cycle (latency 1).
REQ-015 While `rsp_valid`=1 and `rsp_ready`=0, all `rsp_*` outputs SHALL hold stable.
REQ-016 Drain and new grant in the same cycle SHALL replace the buffer with no bubble (throughput 1 op/cycle).
REQ-017 Drain without a grant SHALL clear `rsp_valid` on the next edge.
REQ-018 `i_flush`=1 SHALL clear `rsp_valid` on the next edge regardless of `rsp_ready`, and both readies SHALL be 0 that cycle.
REQ-019 Arbitration state SHALL be a 1-bit `last` pointer (port last granted), updated only on a transfer.

Reset
REQ-020 On `i_rst`=1, asynchronously: `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_eq`=0, `rsp_slt`=0 and `last`=1, so port 0 wins the first contention.
REQ-021 While `i_rst`=1: both `reqN_ready`=0 and execute-unit outputs are all zeros.
REQ-022 Reset mid-stall SHALL discard the buffered result; no response SHALL appear after reset deasserts.

Configuration
REQ-023 Macro `EXEC_ARB_ROUND_ROBIN_EN` defined: when both ports are valid, the port other than `last` SHALL be granted; a single valid port SHALL be granted alone.
REQ-024 Macro undefined: fixed priority, with port 0 always winning contention; `last` SHALL still exist but be unused in the decision.

Verification
REQ-025 Single op: `req0` with op add, rs1=5, rs2=7, src=0, with `rsp_ready`=1 -> `req0_ready`=1 in cycle T; at T+1 `rsp_valid`=1, `rsp_id`=0, `rsp_result`=12.
REQ-026 Contention with the macro defined: both ports valid for 4 cycles, `rsp_ready`=1 -> grants 0,1,0,1 and `rsp_id` sequence 0,1,0,1; without the macro -> 0,0,0,0.
REQ-027 Backpressure: buffer full, `rsp_ready`=0 for 3 cycles -> both readies 0 and `rsp_*` unchanged; `rsp_ready`=1 with `req1` valid -> drain and grant in the same cycle.
REQ-028 Immediate path: `req1`, src=1, rs1=0xFFFFFFFF, imm=1, op slt -> `rs2_data`/`immediate` driven from port 1 and `rsp_slt`=1 captured.
REQ-029 Flush: `rsp_valid`=1, `i_flush`=1 with `req0` valid -> no grant; `rsp_valid`=0 the next cycle.
REQ-030 Async reset asserted mid-stall between clock edges -> `rsp_valid`=0 immediately; first contention after release grants port 0.

Source files
------------

// File: rtl/exec_arbiter.sv
// exec_arbiter: two-port arbiter in front of a shared combinational execute unit.
//
// The winning requester's operation fields drive the execute unit in the grant cycle.
// The unit's result, flags and the winning port number are captured into a one-entry
// response buffer, presented one cycle later (rsp_valid).
//
// Ports:
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_flush                         drop the buffered response, block grants this cycle
//   reqN_valid / reqN_ready         request handshake for port N (N = 0, 1)
//   reqN_alu_op/_alu_src/_rs1/_rs2/_imm  operation fields of port N
//   alu_op, alu_src_op, rs1_data, rs2_data, immediate  drive to the execute unit
//   alu_result, o_eq, o_slt         combinational results from the execute unit
//   rsp_valid/rsp_ready, rsp_id, rsp_result, rsp_eq, rsp_slt  buffered response
//
// Configuration macro: EXEC_ARB_ROUND_ROBIN_EN
//   defined   - on contention the port other than the last granted one wins
//   undefined - fixed priority, port 0 always wins contention
module exec_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_alu_op,
    input  logic        req0_alu_src,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic [31:0] req0_imm,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_alu_op,
    input  logic        req1_alu_src,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    input  logic [31:0] req1_imm,
    output logic [2:0]  alu_op,
    output logic        alu_src_op,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] immediate,
    input  logic [31:0] alu_result,
    input  logic        o_eq,
    input  logic        o_slt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_eq,
    output logic        rsp_slt
);

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_eq_q, rsp_eq_d;
    logic        rsp_slt_q, rsp_slt_d;
    logic        last_q, last_d;

    logic buf_free;
    logic can_grant;
    logic pick1;
    logic grant;

    // Buffer can accept when empty or being drained in this same cycle.
    assign buf_free  = !rsp_valid_q || rsp_ready;
    // i_rst gates grants combinationally so no handshake completes during reset.
    assign can_grant = !i_rst && !i_flush && buf_free;
    assign grant     = can_grant && (req0_valid || req1_valid);

    always_comb begin
        pick1 = 1'b0;
`ifdef EXEC_ARB_ROUND_ROBIN_EN
        if (req0_valid && req1_valid) begin
            pick1 = !last_q;
        end else begin
            pick1 = req1_valid;
        end
`else
        pick1 = !req0_valid && req1_valid;
`endif
    end

    assign req0_ready = grant && !pick1;
    assign req1_ready = grant && pick1;

    always_comb begin
        alu_op     = 3'd0;
        alu_src_op = 1'b0;
        rs1_data   = 32'd0;
        rs2_data   = 32'd0;
        immediate  = 32'd0;
        if (grant) begin
            if (pick1) begin
                alu_op     = req1_alu_op;
                alu_src_op = req1_alu_src;
                rs1_data   = req1_rs1;
                rs2_data   = req1_rs2;
                immediate  = req1_imm;
            end else begin
                alu_op     = req0_alu_op;
                alu_src_op = req0_alu_src;
                rs1_data   = req0_rs1;
                rs2_data   = req0_rs2;
                immediate  = req0_imm;
            end
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_eq_d     = rsp_eq_q;
        rsp_slt_d    = rsp_slt_q;
        // Pointer only moves on a transfer; in fixed-priority builds it is tracked but unused.
        last_d       = grant ? pick1 : last_q;
        if (i_flush) begin
            rsp_valid_d = 1'b0;
        end else if (grant) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = pick1;
            rsp_result_d = alu_result;
            rsp_eq_d     = o_eq;
            rsp_slt_d    = o_slt;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_eq_q     <= 1'b0;
            rsp_slt_q    <= 1'b0;
            last_q       <= 1'b1;  // port 0 wins the first contention
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_eq_q     <= rsp_eq_d;
            rsp_slt_q    <= rsp_slt_d;
            last_q       <= last_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_eq     = rsp_eq_q;
    assign rsp_slt    = rsp_slt_q;

endmodule

// File: tb/tb_exec_arbiter.sv
// Testbench for exec_arbiter: table of per-cycle vectors plus a hand-written
// asynchronous-reset-mid-stall sequence. The bench also plays the execute unit.
module tb_exec_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_flush;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_alu_op, req1_alu_op;
    logic        req0_alu_src, req1_alu_src;
    logic [31:0] req0_rs1, req0_rs2, req0_imm;
    logic [31:0] req1_rs1, req1_rs2, req1_imm;
    logic [2:0]  alu_op;
    logic        alu_src_op;
    logic [31:0] rs1_data, rs2_data, immediate;
    logic [31:0] alu_result;
    logic        o_eq, o_slt;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_eq, rsp_slt;

    always #5 i_clk = ~i_clk;

    // Execute unit encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed).
    function automatic logic [33:0] alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        logic        lt;
        lt = $signed(a) < $signed(b);
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = {31'd0, lt};
            default: r = 32'd0;
        endcase
        return {a == b, lt, r};
    endfunction

    assign {o_eq, o_slt, alu_result} = alu(alu_op, rs1_data,
                                           alu_src_op ? immediate : rs2_data);

    exec_arbiter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_alu_op  (req0_alu_op),
        .req0_alu_src (req0_alu_src),
        .req0_rs1     (req0_rs1),
        .req0_rs2     (req0_rs2),
        .req0_imm     (req0_imm),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_alu_op  (req1_alu_op),
        .req1_alu_src (req1_alu_src),
        .req1_rs1     (req1_rs1),
        .req1_rs2     (req1_rs2),
        .req1_imm     (req1_imm),
        .alu_op       (alu_op),
        .alu_src_op   (alu_src_op),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .immediate    (immediate),
        .alu_result   (alu_result),
        .o_eq         (o_eq),
        .o_slt        (o_slt),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_eq       (rsp_eq),
        .rsp_slt      (rsp_slt)
    );

    typedef struct {
        logic        v0, v1;
        logic [2:0]  op0;
        logic        s0;
        logic [31:0] a0, b0, i0;
        logic [2:0]  op1;
        logic        s1;
        logic [31:0] a1, b1, i1;
        logic        rr, fl;
        logic [1:0]  efp, err;  // expected {ready1, ready0}: fixed priority / round robin
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        eq, slt;
    } exp_t;

    exp_t q[$];
    logic valid_m;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one vector for one cycle; inputs change #1 after posedge, checks at negedge.
    task automatic step(input vec_t v, input string tag);
        logic [1:0]  eg;
        logic        p1;
        logic [33:0] r;
        exp_t        e;
        req0_valid = v.v0; req0_alu_op = v.op0; req0_alu_src = v.s0;
        req0_rs1 = v.a0; req0_rs2 = v.b0; req0_imm = v.i0;
        req1_valid = v.v1; req1_alu_op = v.op1; req1_alu_src = v.s1;
        req1_rs1 = v.a1; req1_rs2 = v.b1; req1_imm = v.i1;
        rsp_ready = v.rr; i_flush = v.fl;
        @(negedge i_clk);
`ifdef EXEC_ARB_ROUND_ROBIN_EN
        eg = v.err;
`else
        eg = v.efp;
`endif
        p1 = eg[1];
        chk({tag, " req0_ready"}, {31'd0, req0_ready}, {31'd0, eg[0]});
        chk({tag, " req1_ready"}, {31'd0, req1_ready}, {31'd0, eg[1]});
        if (eg != 2'b00) begin
            chk({tag, " alu_op"},    {29'd0, alu_op}, {29'd0, p1 ? v.op1 : v.op0});
            chk({tag, " alu_src"},   {31'd0, alu_src_op}, {31'd0, p1 ? v.s1 : v.s0});
            chk({tag, " rs1_data"},  rs1_data,  p1 ? v.a1 : v.a0);
            chk({tag, " rs2_data"},  rs2_data,  p1 ? v.b1 : v.b0);
            chk({tag, " immediate"}, immediate, p1 ? v.i1 : v.i0);
        end else begin
            chk({tag, " exec idle"}, {29'd0, alu_op} | rs1_data | rs2_data | immediate
                                     | {31'd0, alu_src_op}, 32'd0);
        end
        chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, {31'd0, valid_m});
        if (valid_m) begin
            if (q.size() == 0) begin
                chk({tag, " scoreboard underflow"}, 32'd1, 32'd0);
            end else begin
                chk({tag, " rsp_id"},     {31'd0, rsp_id},  {31'd0, q[0].id});
                chk({tag, " rsp_result"}, rsp_result,       q[0].res);
                chk({tag, " rsp_eq"},     {31'd0, rsp_eq},  {31'd0, q[0].eq});
                chk({tag, " rsp_slt"},    {31'd0, rsp_slt}, {31'd0, q[0].slt});
            end
        end
        if (valid_m && (v.fl || v.rr) && q.size() != 0) void'(q.pop_front());
        if (eg != 2'b00) begin
            r = p1 ? alu(v.op1, v.a1, v.s1 ? v.i1 : v.b1)
                   : alu(v.op0, v.a0, v.s0 ? v.i0 : v.b0);
            e.id = p1; e.res = r[31:0]; e.slt = r[32]; e.eq = r[33];
            q.push_back(e);
        end
        if (v.fl)                 valid_m = 1'b0;
        else if (eg != 2'b00)     valid_m = 1'b1;
        else if (v.rr)            valid_m = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    localparam logic [31:0] F = 32'hFFFF_FFFF;
    vec_t tbl[16];
    vec_t idle_v;

    initial begin
        // Contention straight out of reset: RR gives 0,1,0,1; fixed gives 0,0,0,0.
        tbl[0]  = '{1,1, 0,0,32'd1,32'd2,0,  0,0,32'd10,32'd3,0, 1,0, 2'b01, 2'b01};
        tbl[1]  = '{1,1, 0,0,32'd2,32'd2,0,  0,0,32'd20,32'd3,0, 1,0, 2'b01, 2'b10};
        tbl[2]  = '{1,1, 0,0,32'd3,32'd2,0,  0,0,32'd30,32'd3,0, 1,0, 2'b01, 2'b01};
        tbl[3]  = '{1,1, 0,0,32'd4,32'd2,0,  0,0,32'd40,32'd3,0, 1,0, 2'b01, 2'b10};
        // Single add 5+7 while draining.
        tbl[4]  = '{1,0, 0,0,32'd5,32'd7,0,  0,0,0,0,0,          1,0, 2'b01, 2'b01};
        // Backpressure: full buffer, rsp_ready low for 3 cycles.
        tbl[5]  = '{1,1, 0,0,32'd8,32'd8,0,  1,0,32'd9,32'd1,0,  0,0, 2'b00, 2'b00};
        tbl[6]  = '{1,1, 0,0,32'd8,32'd8,0,  1,0,32'd9,32'd1,0,  0,0, 2'b00, 2'b00};
        tbl[7]  = '{1,1, 0,0,32'd8,32'd8,0,  1,0,32'd9,32'd1,0,  0,0, 2'b00, 2'b00};
        // Drain and grant port 1 in the same cycle.
        tbl[8]  = '{0,1, 0,0,0,0,0, 2,0,32'h0000_F0F0,32'h0000_FF00,0, 1,0, 2'b10, 2'b10};
        // Immediate path: -1 slt imm 1.
        tbl[9]  = '{0,1, 0,0,0,0,0, 5,1,F,32'd5,32'd1,         1,0, 2'b10, 2'b10};
        // Flush with port 0 valid and a full buffer.
        tbl[10] = '{1,0, 0,0,32'd1,32'd1,0,  0,0,0,0,0,          0,1, 2'b00, 2'b00};
        tbl[11] = '{0,0, 0,0,0,0,0,          0,0,0,0,0,          1,0, 2'b00, 2'b00};
        // Grant into empty buffer with rsp_ready low; eq flag case.
        tbl[12] = '{1,0, 1,0,32'd9,32'd9,0,  0,0,0,0,0,          0,0, 2'b01, 2'b01};
        tbl[13] = '{0,1, 0,0,0,0,0,          0,0,32'd1,32'd1,0,  0,0, 2'b00, 2'b00};
        // Drain without grant, then empty.
        tbl[14] = '{0,0, 0,0,0,0,0,          0,0,0,0,0,          1,0, 2'b00, 2'b00};
        tbl[15] = '{0,0, 0,0,0,0,0,          0,0,0,0,0,          1,0, 2'b00, 2'b00};
        idle_v  = '{0,0, 0,0,0,0,0,          0,0,0,0,0,          1,0, 2'b00, 2'b00};

        // Reset state, with requests present to prove readies are gated.
        i_rst = 1'b1; i_flush = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_alu_op = 3'd1; req0_alu_src = 1'b1; req0_rs1 = 32'd3; req0_rs2 = 32'd4;
        req0_imm = 32'd5;
        req1_alu_op = 3'd2; req1_alu_src = 1'b0; req1_rs1 = 32'd6; req1_rs2 = 32'd7;
        req1_imm = 32'd8;
        valid_m = 1'b0;
        #3;
        chk("reset rsp_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_id",     {31'd0, rsp_id}, 32'd0);
        chk("reset rsp_result", rsp_result, 32'd0);
        chk("reset flags",      {30'd0, rsp_eq, rsp_slt}, 32'd0);
        chk("reset readies",    {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("reset exec",       {29'd0, alu_op} | rs1_data | rs2_data | immediate, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            step(tbl[k], $sformatf("vec%0d", k));
        end

        // Fill and stall, then assert reset between clock edges.
        begin
            vec_t fill_v, stall_v, both_v;
            fill_v  = '{1,0, 0,0,32'h11,32'h22,0, 0,0,0,0,0, 0,0, 2'b01, 2'b01};
            stall_v = '{1,1, 0,0,32'd1,32'd1,0,   0,0,32'd1,32'd1,0, 0,0, 2'b00, 2'b00};
            both_v  = '{1,1, 0,0,32'd100,32'd1,0, 0,0,32'd200,32'd1,0, 1,0, 2'b01, 2'b01};
            step(fill_v, "fill");
            step(stall_v, "stall");
            #3;
            i_rst = 1'b1;
            #1;
            chk("async rst rsp_valid",  {31'd0, rsp_valid}, 32'd0);
            chk("async rst rsp_result", rsp_result, 32'd0);
            chk("async rst readies",    {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("async rst exec",       {29'd0, alu_op} | rs1_data, 32'd0);
            q.delete();
            valid_m = 1'b0;
            @(posedge i_clk);
            #1;
            chk("in rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
            i_rst = 1'b0;
            step(both_v, "post-rst contention");
            step(idle_v, "post-rst rsp");
            step(idle_v, "post-rst empty");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
